// File: rtl/cb_exec_if.sv
// cb_exec_if: bundles the start/status, register-file, memory, flag and ALU
// signals of the CB opcode executor; slave is the executor, master the environment.
interface cb_exec_if;
  logic        start;
  logic [7:0]  opcode;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  reg_sel;
  logic [7:0]  reg_rdata;
  logic        reg_we;
  logic [7:0]  reg_wdata;
  logic [15:0] hl;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [3:0]  f_in;
  logic [3:0]  f_out;
  logic        f_we;
  logic [7:0]  alu_op;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [3:0]  alu_fin;
  logic [15:0] alu_o;
  logic [3:0]  alu_fout;

  modport slave (
    input  start, opcode, reg_rdata, hl, mem_rdata, mem_ack, f_in, alu_o, alu_fout,
    output busy, done, err, reg_sel, reg_we, reg_wdata, mem_req, mem_we, mem_addr,
           mem_wdata, f_out, f_we, alu_op, alu_x, alu_y, alu_fin
  );

  modport master (
    output start, opcode, reg_rdata, hl, mem_rdata, mem_ack, f_in, alu_o, alu_fout,
    input  busy, done, err, reg_sel, reg_we, reg_wdata, mem_req, mem_we, mem_addr,
           mem_wdata, f_out, f_we, alu_op, alu_x, alu_y, alu_fin
  );
endinterface

// File: rtl/cb_exec.sv
// cb_exec: executes one CB-prefixed rotate/shift/BIT/RES/SET opcode through an external ALU.
// Define CB_MEM_OPERAND_EN to support the (HL) memory operand; otherwise it raises err.
module cb_exec (
  input logic      clk,
  input logic      reset,
  cb_exec_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for start
  // READ  | fetching operand from register file or memory at latched HL
  // EXEC  | capturing ALU result and flags
  // WB    | writing result back, updating flags
  // DONE  | one-cycle completion pulse
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] READ = 3'd1;
  localparam logic [2:0] EXEC = 3'd2;
  localparam logic [2:0] WB   = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [7:0] ALU_RLC  = 8'h20;
  localparam logic [7:0] ALU_RRC  = 8'h21;
  localparam logic [7:0] ALU_RL   = 8'h22;
  localparam logic [7:0] ALU_RR   = 8'h23;
  localparam logic [7:0] ALU_SLA  = 8'h24;
  localparam logic [7:0] ALU_SRA  = 8'h25;
  localparam logic [7:0] ALU_SWAP = 8'h26;
  localparam logic [7:0] ALU_SRL  = 8'h27;
  localparam logic [3:0] CLS_BIT  = 4'h4;
  localparam logic [3:0] CLS_RES  = 4'h8;
  localparam logic [3:0] CLS_SET  = 4'hC;

  logic [2:0]  state;
  logic [1:0]  opClass;
  logic [2:0]  regIdx;
  logic [15:0] hlReg;
  logic [7:0]  operand;
  logic [7:0]  result;
  logic [3:0]  flagsReg;
  logic [7:0]  aluOpReg;
  logic        memOp;
  logic        isBit;
  logic        flagOp;
  logic        wbDone;
  logic        unusedBits;

  function automatic logic [7:0] aluOpOf(input logic [7:0] op);
    logic [7:0] code;
    code = ALU_RLC;
    case (op[7:6])
      2'b00: begin
        case (op[5:3])
          3'd0:    code = ALU_RLC;
          3'd1:    code = ALU_RRC;
          3'd2:    code = ALU_RL;
          3'd3:    code = ALU_RR;
          3'd4:    code = ALU_SLA;
          3'd5:    code = ALU_SRA;
          3'd6:    code = ALU_SWAP;
          default: code = ALU_SRL;
        endcase
      end
      2'b01:   code = {CLS_BIT, 1'b0, op[5:3]};
      2'b10:   code = {CLS_RES, 1'b0, op[5:3]};
      default: code = {CLS_SET, 1'b0, op[5:3]};
    endcase
    return code;
  endfunction

  assign memOp  = (regIdx == 3'd6);
  assign isBit  = (opClass == 2'b01);
  assign flagOp = ~opClass[1];

`ifdef CB_MEM_OPERAND_EN
  // BIT on (HL) never writes memory, so WB finishes without waiting for an ack.
  assign wbDone     = ~(memOp & ~isBit) | bus.mem_ack;
  assign bus.mem_req = memOp & ((state == READ) | ((state == WB) & ~isBit));
  assign bus.mem_we  = memOp & (state == WB) & ~isBit;
  assign bus.err     = 1'b0;
  assign unusedBits  = ^bus.alu_o[15:8];
`else
  assign wbDone     = 1'b1;
  assign bus.mem_req = 1'b0;
  assign bus.mem_we  = 1'b0;
  assign bus.err     = (state == READ) & memOp;
  assign unusedBits  = ^{bus.alu_o[15:8], bus.mem_ack, bus.mem_rdata};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      opClass  <= 2'b00;
      regIdx   <= 3'd0;
      hlReg    <= 16'h0000;
      operand  <= 8'h00;
      result   <= 8'h00;
      flagsReg <= 4'h0;
      aluOpReg <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            opClass  <= bus.opcode[7:6];
            regIdx   <= bus.opcode[2:0];
            hlReg    <= bus.hl;
            aluOpReg <= aluOpOf(bus.opcode);
            state    <= READ;
          end
        end
        READ: begin
          if (memOp) begin
`ifdef CB_MEM_OPERAND_EN
            if (bus.mem_ack) begin
              operand <= bus.mem_rdata;
              state   <= EXEC;
            end
`else
            state <= IDLE;
`endif
          end else begin
            operand <= bus.reg_rdata;
            state   <= EXEC;
          end
        end
        EXEC: begin
          result   <= bus.alu_o[7:0];
          flagsReg <= bus.alu_fout;
          state    <= WB;
        end
        WB: begin
          if (wbDone) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.reg_sel   = regIdx;
  assign bus.reg_we    = (state == WB) & ~memOp & ~isBit;
  assign bus.reg_wdata = result;
  assign bus.mem_addr  = hlReg;
  assign bus.mem_wdata = result;
  // Flags are committed on the last WB cycle so an aborted memory write leaves them untouched.
  assign bus.f_we      = (state == WB) & wbDone & flagOp;
  assign bus.f_out     = flagsReg;
  assign bus.alu_op    = aluOpReg;
  assign bus.alu_x     = {8'h00, operand};
  assign bus.alu_y     = 16'h0000;
  assign bus.alu_fin   = bus.f_in;
endmodule
